// File: rtl/ex_muldiv_unit_if.sv
// Operand, forwarding and result bundle shared by the EX stage and the
// multiply/divide unit.
interface ex_muldiv_unit_if #(parameter int DATA_W = 32);
   logic              i_valid;
   logic [3:0]        i_md_op;
   logic [DATA_W-1:0] i_read_data_1;
   logic [DATA_W-1:0] i_read_data_2;
   logic [1:0]        i_forward_a;
   logic [1:0]        i_forward_b;
   logic [DATA_W-1:0] i_mem_alu_result;
   logic [DATA_W-1:0] i_wb_write_data;
   logic              i_flush;
   logic              o_stall;
   logic              o_busy;
   logic [DATA_W-1:0] o_result;
   logic [DATA_W-1:0] o_hi;
   logic [DATA_W-1:0] o_lo;

   modport master (
      output i_valid, i_md_op, i_read_data_1, i_read_data_2, i_forward_a,
             i_forward_b, i_mem_alu_result, i_wb_write_data, i_flush,
      input  o_stall, o_busy, o_result, o_hi, o_lo
   );

   modport slave (
      input  i_valid, i_md_op, i_read_data_1, i_read_data_2, i_forward_a,
             i_forward_b, i_mem_alu_result, i_wb_write_data, i_flush,
      output o_stall, o_busy, o_result, o_hi, o_lo
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one bit per cycle.
// Define MD_FAST_MUL_EN to compute multiplies in a single RUN step.
module ex_muldiv_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic             clk,
   input  logic             reset,
   ex_muldiv_unit_if.slave  md
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [DATA_W-1:0]   opnd_q, opnd_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic                is_div_q, is_div_d;
   logic                neg_q, neg_d;
   logic                rneg_q, rneg_d;
   logic                dz_q, dz_d;

   logic [DATA_W-1:0]   opa, opb, abs_a, abs_b;
   logic                sa, sb, signed_op, md_op, busy, stall, accept;
   logic [DATA_W:0]     mul_sum, div_trial;
   logic [2*DATA_W-1:0] mul_step, div_step, prod_fix;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   always_comb begin
      case (md.i_forward_a)
         2'b01:   opa = md.i_mem_alu_result;
         2'b10:   opa = md.i_wb_write_data;
         default: opa = md.i_read_data_1;
      endcase
      case (md.i_forward_b)
         2'b01:   opb = md.i_mem_alu_result;
         2'b10:   opb = md.i_wb_write_data;
         default: opb = md.i_read_data_2;
      endcase
   end

   assign signed_op = (md.i_md_op == OP_MULT) || (md.i_md_op == OP_DIV);
   assign sa        = signed_op & opa[DATA_W-1];
   assign sb        = signed_op & opb[DATA_W-1];
   assign abs_a     = sa ? -opa : opa;
   assign abs_b     = sb ? -opb : opb;

   assign md_op  = md.i_valid && (md.i_md_op >= OP_MULT) && (md.i_md_op <= OP_MTLO);
   assign busy   = (state_q != IDLE);
   assign stall  = md_op & busy & ~md.i_flush;
   assign accept = md.i_valid & ~stall & ~md.i_flush;

   // Multiply: acc = {partial, multiplier}; add into the top half, shift right.
   assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_step = {mul_sum, acc_q[DATA_W-1:1]};

   // Divide: acc = {remainder, dividend/quotient}; restoring trial subtract.
   assign div_trial = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, opnd_q};
   assign div_step  = div_trial[DATA_W] ? {acc_q[2*DATA_W-2:0], 1'b0}
                                        : {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

   assign prod_fix = neg_q  ? -acc_q : acc_q;
   assign quo_fix  = neg_q  ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
   assign rem_fix  = rneg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               case (md.i_md_op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     is_div_d = (md.i_md_op == OP_DIV) || (md.i_md_op == OP_DIVU);
                     acc_d    = {{DATA_W{1'b0}}, is_div_d ? abs_a : abs_b};
                     opnd_d   = is_div_d ? abs_b : abs_a;
                     neg_d    = sa ^ sb;
                     rneg_d   = sa;
                     dz_d     = (opb == '0);
                     cnt_d    = '0;
                     state_d  = RUN;
                  end
                  OP_MTHI: hi_d = opa;
                  OP_MTLO: lo_d = opa;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_q) begin
               acc_d = div_step;
               if (cnt_q == CNT_W'(DATA_W-1)) state_d = FIX;
            end else begin
`ifdef MD_FAST_MUL_EN
               acc_d   = {{DATA_W{1'b0}}, opnd_q} * {{DATA_W{1'b0}}, acc_q[DATA_W-1:0]};
               state_d = FIX;
`else
               acc_d = mul_step;
               if (cnt_q == CNT_W'(DATA_W-1)) state_d = FIX;
`endif
            end
         end
         FIX: begin
            state_d = IDLE;
            if (is_div_q) begin
               // Divide by zero leaves HI = A (|A| re-signed) and LO = all ones.
               lo_d = dz_q ? '1 : quo_fix;
               hi_d = rem_fix;
            end else begin
               hi_d = prod_fix[2*DATA_W-1:DATA_W];
               lo_d = prod_fix[DATA_W-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
      // Flush abandons the operation without touching HI/LO.
      if (busy && md.i_flush) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
      end
   end

   assign md.o_stall  = stall;
   assign md.o_busy   = busy;
   assign md.o_hi     = hi_q;
   assign md.o_lo     = lo_q;
   assign md.o_result = (accept && md.i_md_op == OP_MFHI) ? hi_q :
                        (accept && md.i_md_op == OP_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: random and directed ops against an
// arithmetic reference model; a monitor checks HI/LO and MFHI/MFLO results.
module tb_ex_muldiv_unit;
   localparam int W = 32;
`ifdef MD_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = W + 1;
`endif

   typedef struct { logic [W-1:0] hi; logic [W-1:0] lo; } hl_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_muldiv_unit_if #(.DATA_W(W)) bus();
   ex_muldiv_unit #(.DATA_W(W), .CNT_W(6)) dut (.clk(clk), .reset(reset), .md(bus));

   hl_t          wbq[$];
   logic [W-1:0] resq[$];
   logic [W-1:0] m_hi = '0, m_lo = '0;
   int total = 0, bad = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Returns {HI, LO} from plain signed/unsigned 64-bit arithmetic.
   function automatic logic [63:0] md_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      logic [63:0] p;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = {32'b0, a};           ub = {32'b0, b};
      p = '0;
      case (op)
         4'd1: p = sa * sb;
         4'd2: p = ua * ub;
         4'd3, 4'd4: begin
            if (b == '0) p = {a, 32'hFFFF_FFFF};
            else if (op == 4'd3) begin
               q = sa / sb; r = sa % sb;
               p = {r[31:0], q[31:0]};
            end else begin
               uq = ua / ub; ur = ua % ub;
               p = {ur[31:0], uq[31:0]};
            end
         end
         default: p = '0;
      endcase
      return p;
   endfunction

   // Starts right after a rising edge; holds the slot until accepted.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] rd1, input logic [W-1:0] rd2,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [W-1:0] mem, input logic [W-1:0] wbd,
                        input bit abort, output int stalls);
      logic [W-1:0] a, b;
      logic [63:0]  r;
      a = (fa == 2'd1) ? mem : (fa == 2'd2) ? wbd : rd1;
      b = (fb == 2'd1) ? mem : (fb == 2'd2) ? wbd : rd2;
      if (abort) wbq.push_back('{m_hi, m_lo});
      else case (op)
         4'd1, 4'd2, 4'd3, 4'd4: begin
            r = md_ref(op, a, b);
            m_hi = r[63:32]; m_lo = r[31:0];
            wbq.push_back('{m_hi, m_lo});
         end
         4'd5: resq.push_back(m_hi);
         4'd6: resq.push_back(m_lo);
         4'd7: m_hi = a;
         4'd8: m_lo = a;
         default: ;
      endcase
      bus.i_valid = 1'b1; bus.i_md_op = op;
      bus.i_read_data_1 = rd1; bus.i_read_data_2 = rd2;
      bus.i_forward_a = fa; bus.i_forward_b = fb;
      bus.i_mem_alu_result = mem; bus.i_wb_write_data = wbd;
      stalls = 0;
      @(negedge clk);
      while (bus.o_stall && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 200) begin
         total++; bad++;
         $display("FAIL issue_timeout op=%0d stalls=%0d need<200", op, stalls);
      end
      @(posedge clk); #1;
      bus.i_valid = 1'b0; bus.i_md_op = 4'd0;
   endtask

   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int st;
      issue(op, a, b, 2'd0, 2'd0, '0, '0, 1'b0, st);
   endtask

   function automatic logic [W-1:0] rnd32();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return W'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: HI/LO at every end of an operation, o_result at every MF accept.
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      if (prev_busy && !bus.o_busy) begin
         if (wbq.size() == 0) begin
            total++; bad++;
            $display("FAIL hilo_unexpected act=%h exp=none", {bus.o_hi, bus.o_lo});
         end else begin
            hl_t e;
            e = wbq.pop_front();
            check("hilo", {bus.o_hi, bus.o_lo}, {e.hi, e.lo});
         end
      end
      if (reset && bus.i_valid && !bus.o_stall && !bus.i_flush &&
          (bus.i_md_op == 4'd5 || bus.i_md_op == 4'd6)) begin
         if (resq.size() == 0) begin
            total++; bad++;
            $display("FAIL mf_unexpected act=%h exp=none", bus.o_result);
         end else check("mf_result", {32'b0, bus.o_result}, {32'b0, resq.pop_front()});
      end
      prev_busy = bus.o_busy;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, n;
      reset = 1'b0;
      bus.i_valid = 1'b0; bus.i_md_op = '0; bus.i_flush = 1'b0;
      bus.i_read_data_1 = '0; bus.i_read_data_2 = '0;
      bus.i_forward_a = '0; bus.i_forward_b = '0;
      bus.i_mem_alu_result = '0; bus.i_wb_write_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_busy",  {63'b0, bus.o_busy},  64'd0);
      check("rst_stall", {63'b0, bus.o_stall}, 64'd0);
      check("rst_res",   {32'b0, bus.o_result}, 64'd0);
      check("rst_hilo",  {bus.o_hi, bus.o_lo}, 64'd0);
      @(posedge clk); #1;

      // MULT -3*7 followed by a dependent MFLO
      do_op(4'd1, 32'hFFFF_FFFD, 32'd7);
      issue(4'd6, '0, '0, 2'd0, 2'd0, '0, '0, 1'b0, st);
      check("mflo_stall_cycles", 64'(st), 64'(MUL_LAT));
      check("mult_neg_hilo", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFF_FFFF_FFEB);

      // Divides, divide by zero, signed overflow, MULTU max
      do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
      do_op(4'd4, 32'h8000_0000, 32'd0);
      do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(4'd5, '0, '0, 2'd0, 2'd0, '0, '0, 1'b0, st);
      check("multu_max_hilo", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFE_0000_0001);
      do_op(4'd3, 32'd7, 32'd0);
      do_op(4'd3, 32'hFFFF_FFF9, 32'd0);

      // Forwarding: MEM on A, WB on B
      issue(4'd1, 32'd9, 32'd3, 2'd1, 2'd0, 32'd5, 32'd0, 1'b0, st);
      issue(4'd6, '0, '0, 2'd0, 2'd0, '0, '0, 1'b0, st);
      issue(4'd1, 32'd9, 32'd3, 2'd0, 2'd2, 32'd0, 32'd4, 1'b0, st);
      issue(4'd6, '0, '0, 2'd0, 2'd0, '0, '0, 1'b0, st);

      // MTHI during RUN stalls, then overwrites the product's HI
      do_op(4'd1, 32'd1000, 32'hFFFF_FF00);
      issue(4'd7, 32'h1234, '0, 2'd0, 2'd0, '0, '0, 1'b0, st);
      check("mthi_stalled", 64'(st > 0), 64'd1);
      do_op(4'd5, '0, '0);
      do_op(4'd6, '0, '0);

      // NONE op during RUN never stalls
      do_op(4'd2, 32'd12345, 32'd678);
      bus.i_valid = 1'b1; bus.i_md_op = 4'd0;
      @(negedge clk);
      check("none_no_stall", {62'b0, bus.o_busy, bus.o_stall}, 64'd2);
      bus.i_md_op = 4'd12;
      @(negedge clk);
      check("bad_code_no_stall", {63'b0, bus.o_stall}, 64'd0);
      @(posedge clk); #1 bus.i_valid = 1'b0; bus.i_md_op = 4'd0;
      do_op(4'd6, '0, '0);

      // Flush at cnt=10 keeps HI/LO; flush on issue accepts nothing
      issue(4'd1, 32'd77, 32'd55, 2'd0, 2'd0, '0, '0, 1'b1, st);
      repeat (10) @(posedge clk);
      #1 bus.i_flush = 1'b1;
      @(posedge clk); #1 bus.i_flush = 1'b0;
      check("flush_idle", {63'b0, bus.o_busy}, 64'd0);
      bus.i_valid = 1'b1; bus.i_md_op = 4'd7; bus.i_read_data_1 = 32'hDEAD; bus.i_forward_a = 2'd0;
      bus.i_flush = 1'b1;
      @(posedge clk); #1 bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_md_op = 4'd0;
      check("flush_issue_busy", {63'b0, bus.o_busy}, 64'd0);
      do_op(4'd5, '0, '0);

      // Reset at cnt=20 abandons the operation immediately
      m_hi = '0; m_lo = '0;
      issue(4'd3, 32'd999, 32'd7, 2'd0, 2'd0, '0, '0, 1'b1, st);
      repeat (20) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("midrst_busy", {63'b0, bus.o_busy}, 64'd0);
      check("midrst_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
      @(posedge clk); #1 reset = 1'b1;

      // Random mix
      for (int i = 0; i < 40; i++) begin
         issue(4'($urandom_range(1, 8)), rnd32(), rnd32(), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), rnd32(), rnd32(), 1'b0, st);
      end
      do_op(4'd5, '0, '0);
      do_op(4'd6, '0, '0);

      n = 0;
      while (bus.o_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("drain_busy", {63'b0, bus.o_busy}, 64'd0);
      check("wbq_empty", 64'(wbq.size()), 64'd0);
      check("resq_empty", 64'(resq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
